// File: rtl/givens_qr_ctrl.sv
// rtl/givens_qr_ctrl.sv - frame sequencer, tag pipeline, credit flow control and result FIFO for the Givens QR array.
// Optional statistics counters are built when GR_CTRL_STATS_EN is defined.
`ifndef WL
`define WL 8
`endif

module givens_qr_ctrl #(
  parameter int N     = 4,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [`WL*N*N-1:0]   in_h,
  input  logic [`WL*N-1:0]     in_y,
  output logic [`WL*N*N-1:0]   rot_h_o,
  output logic [`WL*N-1:0]     rot_y_o,
  input  logic [`WL*N*N-1:0]   rot_h_i,
  input  logic [`WL*N-1:0]     rot_y_i,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [`WL*N*N-1:0]   out_h,
  output logic [`WL*N-1:0]     out_y,
  output logic                 busy,
  output logic [15:0]          frame_cnt,
  output logic [15:0]          stall_cnt
);

  localparam int HW = `WL*N*N;
  localparam int YW = `WL*N;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [LAT:0]    tag_q, tag_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [HW-1:0]   mem_h [DEPTH];
  logic [YW-1:0]   mem_y [DEPTH];
  logic            in_fire, pop, capture;

  assign in_ready  = (state_q == RUN) && (credit_q != '0);
  assign out_valid = (count_q != '0);
  assign busy      = (state_q != IDLE);
  assign in_fire   = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign capture   = tag_q[LAT];
  assign out_h     = mem_h[rd_ptr_q];
  assign out_y     = mem_y[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      DRAIN: begin
        if (enable) state_d = RUN;
        else if ((tag_q == '0) && (count_q == '0)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit covers FIFO occupancy plus frames still inside the array.
  always_comb begin
    tag_d    = tag_q << 1;
    tag_d[0] = in_fire;
    credit_d = credit_q;
    if (in_fire && !pop)      credit_d = credit_q - CW'(1);
    else if (!in_fire && pop) credit_d = credit_q + CW'(1);
    count_d = count_q;
    if (capture && !pop)      count_d = count_q + CW'(1);
    else if (!capture && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      credit_q <= CW'(DEPTH);
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rot_h_o  <= '0;
      rot_y_o  <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      credit_q <= credit_d;
      count_q  <= count_d;
      if (capture) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (in_fire) begin
        rot_h_o <= in_h;
        rot_y_o <= in_y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem_h[wr_ptr_q] <= rot_h_i;
      mem_y[wr_ptr_q] <= rot_y_i;
    end
  end

`ifdef GR_CTRL_STATS_EN
  logic [15:0] frame_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (pop) frame_cnt_q <= frame_cnt_q + 16'd1;
      if ((state_q == RUN) && in_valid && !in_ready) stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign stall_cnt = stall_cnt_q;
`else
  assign frame_cnt = 16'd0;
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_givens_qr_ctrl.sv
// tb/tb_givens_qr_ctrl.sv - directed bench for givens_qr_ctrl with a stand-in 3-stage rotation array.
`ifndef WL
`define WL 8
`endif

module tb_givens_qr_ctrl;
  localparam int N = 4, LAT = 3, DEPTH = 4;
  localparam int HW = `WL*N*N, YW = `WL*N;
`ifdef GR_CTRL_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif
  localparam logic [YW-1:0] KY = {(YW/8){8'h5A}};

  logic clk = 1'b0, rst = 1'b0, enable = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic [HW-1:0] in_h = '0, rot_h_o, rot_h_i, out_h, p_h1, p_h2, p_h3;
  logic [YW-1:0] in_y = '0, rot_y_o, rot_y_i, out_y, p_y1, p_y2, p_y3;
  logic [15:0] frame_cnt, stall_cnt;

  int total = 0, bad = 0;
  int cyc = 0, fire_n = 0, ovf_n = 0;
  logic [HW-1:0] got_h[$];
  logic [YW-1:0] got_y[$];
  int fire_cyc[$], pop_cyc[$];

  givens_qr_ctrl #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_ready(in_ready),
    .in_h(in_h), .in_y(in_y), .rot_h_o(rot_h_o), .rot_y_o(rot_y_o),
    .rot_h_i(rot_h_i), .rot_y_i(rot_y_i), .out_valid(out_valid), .out_ready(out_ready),
    .out_h(out_h), .out_y(out_y), .busy(busy), .frame_cnt(frame_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in rotation array: three register stages, R = ~H, Q^H*y = y ^ KY.
  always @(posedge clk) begin
    p_h1 <= ~rot_h_o; p_h2 <= p_h1; p_h3 <= p_h2;
    p_y1 <= rot_y_o ^ KY; p_y2 <= p_y1; p_y3 <= p_y2;
  end
  assign rot_h_i = p_h3;
  assign rot_y_i = p_y3;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (in_valid && in_ready) begin
      fire_n <= fire_n + 1;
      fire_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      got_h.push_back(out_h);
      got_y.push_back(out_y);
      pop_cyc.push_back(cyc);
    end
    if (rst && dut.tag_q[LAT] && int'(dut.count_q) == DEPTH) ovf_n <= ovf_n + 1;
  end

  function automatic logic [HW-1:0] mk_h(input int i);
    logic [HW-1:0] r;
    for (int k = 0; k < HW/8; k++) r[k*8 +: 8] = 8'(i*7 + 3) ^ 8'(k*17);
    return r;
  endfunction

  function automatic logic [YW-1:0] mk_y(input int i);
    logic [YW-1:0] r;
    for (int k = 0; k < YW/8; k++) r[k*8 +: 8] = 8'(i*13 + 1) ^ 8'(k*29);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    tick; tick;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (frame_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", frame_cnt, stall_cnt); end
    total++; if (rot_h_o !== '0 || rot_y_o !== '0) begin bad++; $display("FAIL reset_rot got=%h exp=0", rot_h_o); end
    rst = 1'b1;
    tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_no_enable got=%b exp=0", busy); end
  endtask

  task automatic test_single_frame;
    int k;
    enable = 1'b1; out_ready = 1'b0;
    tick;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL run_in_ready got=%b exp=1", in_ready); end
    in_h = mk_h(1); in_y = mk_y(1); in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    total++; if (rot_h_o !== mk_h(1) || rot_y_o !== mk_y(1)) begin
      bad++; $display("FAIL issue_rot got=%h exp=%h", rot_y_o, mk_y(1)); end
    k = 0;
    while (!out_valid && k < 20) begin tick; k++; end
    total++; if (k != 4) begin bad++; $display("FAIL single_latency got=%0d exp=4", k); end
    total++; if (out_h !== ~mk_h(1) || out_y !== (mk_y(1) ^ KY)) begin
      bad++; $display("FAIL single_data got=%h exp=%h", out_y, mk_y(1) ^ KY); end
    total++; if (int'(dut.credit_q) != 3) begin bad++; $display("FAIL single_credit_held got=%0d exp=3", dut.credit_q); end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_popped got=%b exp=0", out_valid); end
    total++; if (int'(dut.credit_q) != 4) begin bad++; $display("FAIL single_credit_back got=%0d exp=4", dut.credit_q); end
  endtask

  task automatic test_back_to_back;
    int k, err, g0, f0, d0, d3;
    g0 = got_h.size(); f0 = fire_cyc.size();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_h = mk_h(10 + i); in_y = mk_y(10 + i);
      k = 0;
      while (!in_ready && k < 20) begin tick; k++; end
      tick;
    end
    in_valid = 1'b0;
    k = 0;
    while (got_h.size() < g0 + 16 && k < 40) begin tick; k++; end
    total++; if (got_h.size() != g0 + 16) begin bad++; $display("FAIL b2b_count got=%0d exp=16", got_h.size() - g0); end
    err = 0;
    for (int i = 0; i < 16 && g0 + i < got_h.size(); i++)
      if (got_h[g0+i] !== ~mk_h(10+i) || got_y[g0+i] !== (mk_y(10+i) ^ KY)) err++;
    total++; if (err != 0) begin bad++; $display("FAIL b2b_order got=%0d bad frames exp=0", err); end
    d3 = (fire_cyc.size() >= f0 + 4) ? fire_cyc[f0+3] - fire_cyc[f0] : -1;
    total++; if (d3 != 3) begin bad++; $display("FAIL b2b_first_burst got=%0d exp=3", d3); end
    // 4 credits cover a 5-cycle round trip, so issue runs 4-on/2-off after the first burst.
    d0 = (fire_cyc.size() >= f0 + 16 && pop_cyc.size() >= g0 + 16) ? pop_cyc[g0+15] - fire_cyc[f0] : -1;
    total++; if (d0 != 26) begin bad++; $display("FAIL b2b_span got=%0d exp=26", d0); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int f0, g0, err;
    logic [15:0] s0, c0;
    f0 = fire_n; g0 = got_h.size(); s0 = stall_cnt; c0 = frame_cnt;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin in_h = mk_h(100 + i); in_y = mk_y(100 + i); tick; end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_no_credit got=%b exp=0", in_ready); end
    in_h = mk_h(199); in_y = mk_y(199);
    for (int i = 0; i < 6; i++) tick;
    total++; if (fire_n - f0 != 4) begin bad++; $display("FAIL bp_fires got=%0d exp=4", fire_n - f0); end
    total++; if (16'(stall_cnt - s0) !== 16'(6*STATS)) begin
      bad++; $display("FAIL bp_stall_cnt got=%0d exp=%0d", 16'(stall_cnt - s0), 6*STATS); end
    in_valid = 1'b0; out_ready = 1'b1;
    err = 0;
    for (int i = 1; i <= 4; i++) begin
      tick;
      if (int'(dut.credit_q) != i) err++;
    end
    out_ready = 1'b0;
    total++; if (err != 0) begin bad++; $display("FAIL bp_credit_refill got=%0d bad steps exp=0", err); end
    total++; if (16'(frame_cnt - c0) !== 16'(4*STATS)) begin
      bad++; $display("FAIL bp_frame_cnt got=%0d exp=%0d", 16'(frame_cnt - c0), 4*STATS); end
    err = 0;
    for (int i = 0; i < 4; i++)
      if (g0 + i >= got_h.size() || got_h[g0+i] !== ~mk_h(100+i)) err++;
    total++; if (err != 0) begin bad++; $display("FAIL bp_order got=%0d bad frames exp=0", err); end
  endtask

  task automatic test_full_wrap;
    int k, err, over, g0;
    g0 = got_h.size(); over = 0;
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_h = mk_h(300 + i); in_y = mk_y(300 + i);
      k = 0;
      while (!in_ready && k < 20) begin tick; k++; if (int'(dut.count_q) > DEPTH) over++; end
      tick;
      if (int'(dut.count_q) > DEPTH) over++;
      if (i == 3) begin
        k = 0;
        while (int'(dut.count_q) != DEPTH && k < 20) begin tick; k++; end
        total++; if (int'(dut.count_q) != DEPTH) begin bad++; $display("FAIL wrap_full got=%0d exp=4", dut.count_q); end
        out_ready = 1'b1;
      end
    end
    in_valid = 1'b0;
    k = 0;
    while (got_h.size() < g0 + 10 && k < 40) begin tick; k++; if (int'(dut.count_q) > DEPTH) over++; end
    out_ready = 1'b0;
    total++; if (over != 0) begin bad++; $display("FAIL wrap_count_bound got=%0d exp=0", over); end
    err = 0;
    for (int i = 0; i < 10; i++)
      if (g0 + i >= got_h.size() || got_h[g0+i] !== ~mk_h(300+i) || got_y[g0+i] !== (mk_y(300+i) ^ KY)) err++;
    total++; if (err != 0) begin bad++; $display("FAIL wrap_order got=%0d bad frames exp=0", err); end
    // 31 frames so far: both pointers have wrapped to 31 mod 4.
    total++; if (int'(dut.wr_ptr_q) != 3 || int'(dut.rd_ptr_q) != 3) begin
      bad++; $display("FAIL wrap_ptrs got=%0d/%0d exp=3/3", dut.wr_ptr_q, dut.rd_ptr_q); end
  endtask

  task automatic test_enable_drop;
    int k, err, g0;
    g0 = got_h.size();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin in_h = mk_h(200 + i); in_y = mk_y(200 + i); tick; end
    in_valid = 1'b0;
    tick; tick;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL drop_one_queued got=%b exp=1", out_valid); end
    enable = 1'b0;
    tick;
    total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
      bad++; $display("FAIL drop_drain got=%b%b exp=01", in_ready, busy); end
    out_ready = 1'b1;
    k = 0; err = 0;
    while (got_h.size() < g0 + 3 && k < 20) begin tick; k++; if (busy !== 1'b1) err++; end
    total++; if (err != 0 || got_h.size() != g0 + 3) begin
      bad++; $display("FAIL drop_busy_until_pop got=%0d errs exp=0", err); end
    tick;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL drop_idle got=%b exp=0", busy); end
    err = 0;
    for (int i = 0; i < 3; i++)
      if (g0 + i >= got_h.size() || got_h[g0+i] !== ~mk_h(200+i)) err++;
    total++; if (err != 0) begin bad++; $display("FAIL drop_order got=%0d bad frames exp=0", err); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midflight;
    int g0;
    enable = 1'b1; out_ready = 1'b0;
    tick;
    in_valid = 1'b1;
    in_h = mk_h(400); in_y = mk_y(400); tick;
    in_h = mk_h(401); in_y = mk_y(401); tick;
    in_valid = 1'b0;
    tick; tick; tick;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
    #2 rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_async_reset got=%b%b%b exp=000", in_ready, out_valid, busy); end
    total++; if (rot_h_o !== '0 || frame_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
      bad++; $display("FAIL mid_reset_regs got=%h exp=0", rot_y_o); end
    tick;
    rst = 1'b1;
    g0 = got_h.size();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick;
    total++; if (got_h.size() != g0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL mid_no_stale got=%0d exp=0", got_h.size() - g0); end
    total++; if (int'(dut.credit_q) != DEPTH) begin bad++; $display("FAIL mid_credit got=%0d exp=4", dut.credit_q); end
  endtask

  initial begin
    test_reset;
    test_single_frame;
    test_back_to_back;
    test_backpressure;
    test_full_wrap;
    test_enable_drop;
    test_reset_midflight;
    total++; if (ovf_n != 0) begin bad++; $display("FAIL capture_into_full got=%0d exp=0", ovf_n); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
